// File: rtl/mda_pwm_capture_pkg.sv
// Shared constants for the PWM capture block: register map, status field
// offsets, channel FSM encoding and the sticky-flag update rule.
package mda_pwm_capture_pkg;

   localparam int PERIOD_LENGTH = 16;
   localparam int MAX_CHANNELS  = 8;

   localparam logic [4:0] STATUS_ADDR = 5'd8;
   localparam int VALID_LSB = 0;
   localparam int STALE_LSB = 8;
   localparam int LEVEL_LSB = 16;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MEASURE = 1'b1;

   // A hardware set beats any clear arriving in the same cycle.
   function automatic logic flag_next(input logic cur, input logic hw_set,
                                      input logic hw_clr, input logic sw_clr);
      logic nxt;
      if (hw_set) begin
         nxt = 1'b1;
      end else if (hw_clr || sw_clr) begin
         nxt = 1'b0;
      end else begin
         nxt = cur;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/mda_pwm_capture_channel.sv
// One measured PWM input: synchronizer, edge detect, saturating counter and
// the IDLE/MEASURE capture FSM with sticky valid/stale flags.
module mda_pwm_capture_channel
   import mda_pwm_capture_pkg::*;
#(
   parameter int CNT_WIDTH = PERIOD_LENGTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pin,
   input  logic                 clr_valid,
   input  logic                 clr_stale,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic                 valid,
   output logic                 stale,
   output logic                 level
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                 sync1_r, sync2_r, s_d_r;
   logic                 rise_s, fall_s, sat_s;
   logic                 capture_s, lose_s, high_upd_s;
   logic [0:0]           state_r, state_nxt_s;
   logic [CNT_WIDTH-1:0] cnt_r, high_cnt_r, period_r, high_time_r;
   logic                 valid_r, stale_r;

   // Edge detection and next-state/event decode of the capture FSM.
   always_comb begin
      rise_s      = sync2_r & ~s_d_r;
      fall_s      = ~sync2_r & s_d_r;
      sat_s       = (cnt_r == CNT_MAX);
      capture_s   = 1'b0;
      lose_s      = 1'b0;
      high_upd_s  = 1'b0;
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (rise_s) begin
               state_nxt_s = ST_MEASURE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MEASURE: begin
            // Saturation outranks a coincident fall: that fall is dropped.
            if (rise_s) begin
               capture_s = 1'b1;
            end else if (sat_s) begin
               lose_s      = 1'b1;
               state_nxt_s = ST_IDLE;
            end else if (fall_s) begin
               high_upd_s = 1'b1;
            end else begin
               state_nxt_s = ST_MEASURE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Synchronizer, edge-delay flop and the free-running saturating counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         s_d_r   <= 1'b0;
         cnt_r   <= '0;
      end else begin
         sync1_r <= pin;
         sync2_r <= sync1_r;
         s_d_r   <= sync2_r;
         if (rise_s) begin
            cnt_r <= CNT_ONE;
         end else if (!sat_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // FSM state, measurement registers and sticky status flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         high_cnt_r  <= '0;
         period_r    <= '0;
         high_time_r <= '0;
         valid_r     <= 1'b0;
         stale_r     <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (high_upd_s) begin
            high_cnt_r <= cnt_r;
         end else begin
            high_cnt_r <= high_cnt_r;
         end
         if (capture_s) begin
            period_r    <= cnt_r;
            high_time_r <= high_cnt_r;
         end else begin
            period_r    <= period_r;
            high_time_r <= high_time_r;
         end
         valid_r <= flag_next(valid_r, capture_s, lose_s, clr_valid);
         stale_r <= flag_next(stale_r, lose_s, 1'b0, clr_stale);
      end
   end

   assign period    = period_r;
   assign high_time = high_time_r;
   assign valid     = valid_r;
   assign stale     = stale_r;
   assign level     = sync2_r;

endmodule

// File: rtl/mda_pwm_capture.sv
// Avalon-MM PWM capture: CHANNELS measurement channels plus the read mux
// (latency 1) and write-1-to-clear decode of the status word.
module mda_pwm_capture
   import mda_pwm_capture_pkg::*;
#(
   parameter int CHANNELS  = 8,
   parameter int CNT_WIDTH = PERIOD_LENGTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                chipselect,
   input  logic                read,
   input  logic                write,
   input  logic [4:0]          addr,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   input  logic [CHANNELS-1:0] GPIO_in
);

   logic [31:0] chan_word_s [MAX_CHANNELS];
   logic [7:0]  valid_s, stale_s, level_s;
   logic        status_wr_s;
   logic [31:0] status_s, rd_mux_s, readdata_r;
   logic        unused_s;

   assign status_wr_s = chipselect & write & (addr == STATUS_ADDR);
   assign unused_s    = ^writedata[31:16];

   // Unimplemented channel slots read as zero everywhere.
   for (genvar i = 0; i < MAX_CHANNELS; i++) begin : g_ch
      if (i < CHANNELS) begin : g_used
         logic [CNT_WIDTH-1:0] period_s, high_time_s;

         mda_pwm_capture_channel #(
            .CNT_WIDTH (CNT_WIDTH)
         ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .pin       (GPIO_in[i]),
            .clr_valid (status_wr_s & writedata[VALID_LSB + i]),
            .clr_stale (status_wr_s & writedata[STALE_LSB + i]),
            .period    (period_s),
            .high_time (high_time_s),
            .valid     (valid_s[i]),
            .stale     (stale_s[i]),
            .level     (level_s[i])
         );

         if (CNT_WIDTH >= 16) begin : g_trunc
            assign chan_word_s[i] = {high_time_s[15:0], period_s[15:0]};
         end else begin : g_ext
            assign chan_word_s[i] = {{(16-CNT_WIDTH){1'b0}}, high_time_s,
                                     {(16-CNT_WIDTH){1'b0}}, period_s};
         end
      end else begin : g_unused
         assign chan_word_s[i] = 32'h0000_0000;
         assign valid_s[i]     = 1'b0;
         assign stale_s[i]     = 1'b0;
         assign level_s[i]     = 1'b0;
      end
   end

   // Status word assembly and read address decode.
   always_comb begin
      status_s                    = 32'h0000_0000;
      status_s[VALID_LSB +: 8]    = valid_s;
      status_s[STALE_LSB +: 8]    = stale_s;
      status_s[LEVEL_LSB +: 8]    = level_s;
      rd_mux_s                    = 32'h0000_0000;
      if (addr == STATUS_ADDR) begin
         rd_mux_s = status_s;
      end else if (addr < 5'd8) begin
         rd_mux_s = chan_word_s[addr[2:0]];
      end else begin
         rd_mux_s = 32'h0000_0000;
      end
   end

   // Registered read data; holds its value between reads.
   always_ff @(posedge clk) begin
      if (!reset) begin
         readdata_r <= 32'h0000_0000;
      end else if (chipselect && read) begin
         readdata_r <= rd_mux_s;
      end else begin
         readdata_r <= readdata_r;
      end
   end

   assign readdata = readdata_r;

endmodule

// File: tb/tb_mda_pwm_capture.sv
// Directed bench for mda_pwm_capture: an 8-channel and a 4-channel instance
// share the bus and the lower GPIO lines; expected words are hand-computed.
module tb_mda_pwm_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, read, write;
   logic [4:0]  addr;
   logic [31:0] writedata;
   logic [31:0] readdata8, readdata4;
   logic [7:0]  gpio;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mda_pwm_capture #(.CHANNELS(8), .CNT_WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .chipselect (chipselect),
      .read       (read),
      .write      (write),
      .addr       (addr),
      .writedata  (writedata),
      .readdata   (readdata8),
      .GPIO_in    (gpio)
   );

   mda_pwm_capture #(.CHANNELS(4), .CNT_WIDTH(16)) dut4 (
      .clk        (clk),
      .reset      (reset),
      .chipselect (chipselect),
      .read       (read),
      .write      (write),
      .addr       (addr),
      .writedata  (writedata),
      .readdata   (readdata4),
      .GPIO_in    (gpio[3:0])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Read issued for one cycle; data checked after the next edge and again one cycle later (hold).
   task automatic bus_read(input string tag, input logic [4:0] a,
                           input logic [31:0] exp8, input logic [31:0] exp4);
      addr       = a;
      chipselect = 1'b1;
      read       = 1'b1;
      @(negedge clk);
      chipselect = 1'b0;
      read       = 1'b0;
      check_eq({tag, "_c8"}, readdata8, exp8);
      check_eq({tag, "_c4"}, readdata4, exp4);
      @(negedge clk);
      check_eq({tag, "_h8"}, readdata8, exp8);
      check_eq({tag, "_h4"}, readdata4, exp4);
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      addr       = a;
      writedata  = d;
      chipselect = 1'b1;
      write      = 1'b1;
      @(negedge clk);
      chipselect = 1'b0;
      write      = 1'b0;
      writedata  = 32'h0;
   endtask

   task automatic pwm_period(input logic [7:0] mask, input int high, input int per);
      gpio = gpio | mask;
      tick(high);
      gpio = gpio & ~mask;
      tick(per - high);
   endtask

   initial begin
      reset      = 1'b0;
      chipselect = 1'b1;
      read       = 1'b1;
      write      = 1'b0;
      addr       = 5'd0;
      writedata  = 32'h0;
      gpio       = 8'h00;

      // Reset held with toggling pins and an active read.
      for (int i = 0; i < 5; i++) begin
         gpio = ~gpio;
         @(negedge clk);
         check_eq("rst_rd8", readdata8, 32'h0);
      end
      gpio       = 8'h00;
      chipselect = 1'b0;
      read       = 1'b0;
      reset      = 1'b1;
      tick(4);
      bus_read("rst_a0", 5'd0, 32'h0, 32'h0);
      bus_read("rst_st", 5'd8, 32'h0, 32'h0);

      // ch0 300/1000: first rise arms, second captures.
      pwm_period(8'h01, 300, 1000);
      pwm_period(8'h01, 300, 1000);
      bus_read("ch0_word", 5'd0, 32'h012C_03E8, 32'h012C_03E8);
      bus_read("ch0_st",   5'd8, 32'h0000_0001, 32'h0000_0001);

      // W1C without an edge, then W1C colliding with a capture.
      bus_write(5'd8, 32'h0000_0001);
      bus_read("w1c_st",   5'd8, 32'h0000_0000, 32'h0000_0000);
      bus_read("w1c_word", 5'd0, 32'h012C_03E8, 32'h012C_03E8);
      gpio[0] = 1'b1;
      tick(2);
      bus_write(5'd8, 32'h0000_0001);
      bus_read("w1c_race", 5'd8, 32'h0001_0001, 32'h0001_0001);
      gpio[0] = 1'b0;
      tick(10);

      // ch3 duty change 250/1000 -> 750/1000 with mid-period reads.
      pwm_period(8'h08, 250, 1000);
      gpio[3] = 1'b1;
      tick(250);
      gpio[3] = 1'b0;
      bus_read("ch3_b", 5'd3, 32'h00FA_03E8, 32'h00FA_03E8);
      tick(748);
      gpio[3] = 1'b1;
      tick(750);
      gpio[3] = 1'b0;
      tick(5);
      bus_read("ch3_c", 5'd3, 32'h00FA_03E8, 32'h00FA_03E8);
      tick(243);
      gpio[3] = 1'b1;
      tick(5);
      bus_read("ch3_d", 5'd3, 32'h02EE_03E8, 32'h02EE_03E8);
      tick(743);
      gpio[3] = 1'b0;
      tick(250);

      // Writes outside the status word are ignored; unmapped reads are zero.
      bus_write(5'd3, 32'hFFFF_FFFF);
      bus_write(5'd9, 32'hFFFF_FFFF);
      bus_read("wr_ign_a3", 5'd3, 32'h02EE_03E8, 32'h02EE_03E8);
      bus_read("wr_ign_st", 5'd8, 32'h0000_0009, 32'h0000_0009);
      bus_read("unmap_20",  5'd20, 32'h0, 32'h0);
      bus_read("unmap_7",   5'd7,  32'h0, 32'h0);

      // ch5 100/400 then stuck high: goes stale with level 1.
      pwm_period(8'h20, 100, 400);
      pwm_period(8'h20, 100, 400);
      gpio[5] = 1'b1;
      tick(10);
      bus_read("ch5_word", 5'd5, 32'h0064_0190, 32'h0);
      tick(66000);
      bus_read("stale_st", 5'd8, 32'h0020_2900, 32'h0000_0900);

      // Reapply 150/500 on ch5 and ch7: valid returns after the second rise.
      gpio[5] = 1'b0;
      tick(300);
      pwm_period(8'hA0, 150, 500);
      pwm_period(8'hA0, 150, 500);
      bus_read("ch5_re", 5'd5, 32'h0096_01F4, 32'h0);
      bus_read("ch7_re", 5'd7, 32'h0096_01F4, 32'h0);
      bus_read("re_st",  5'd8, 32'h0000_29A0, 32'h0000_0900);
      bus_write(5'd8, 32'h0000_FFFF);
      bus_read("clr_all", 5'd8, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mda_pwm_capture.md
# mda_pwm_capture

Avalon-MM slave that measures period and high time of up to eight externally generated PWM signals on GPIO inputs. It is the receive-side counterpart of the motor control block: that block writes duty-cycle/period registers and drives PWM out; this block samples PWM in (feedback lines, RC receiver, loopback) and exposes the measured duty cycle and period for the HPS/Nios to read. It sits in the top-level Qsys system beside the motor controller, with GPIO_in wired to input pins.

## Interface
- CHANNELS, 8, number of measured inputs (1..8)
- CNT_WIDTH, 16, measurement counter width; equals `PERIOD_LENGTH` in practice

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- chipselect  in  1  Avalon slave select
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- addr  in  5  word address
- writedata  in  32  write data
- readdata  out  32  read data, fixed read latency 1
- GPIO_in  in  CHANNELS  asynchronous PWM inputs

## Operation
- Per channel: 2-flop synchronizer -> s; s_d = s delayed one cycle; rise = s & ~s_d; fall = ~s & s_d.
- Per-channel counter cnt (CNT_WIDTH): on rise cnt <= 1, else cnt <= cnt+1 saturating at all-ones.
- Per-channel FSM, states IDLE and MEASURE:
  - IDLE: rise -> MEASURE (cnt restarts, nothing latched); fall ignored.
  - MEASURE, fall: high_cnt <= cnt (equals cycles s was high).
  - MEASURE, rise: period <= cnt, high_time <= high_cnt (same cycle, coherent pair), valid <= 1, stay MEASURE.
  - MEASURE, cnt == all-ones and no rise: stale <= 1, valid <= 0, -> IDLE. A fall on that same cycle is discarded.
- Stuck-high/stuck-low (0%/100% duty) therefore reports stale, with level bit giving the stuck value.
- Register map (read):
  - addr 0..CHANNELS-1: {high_time[15:0], period[15:0]} of channel addr (zero-extended if CNT_WIDTH<16).
  - addr 8: [7:0] valid, [15:8] stale, [23:16] current synchronized level s, [31:24] 0.
  - all other addresses, and channels >= CHANNELS: 0.
- Register map (write): addr 8 only; writedata[7:0] write-1-to-clear valid, [15:8] W1C stale. Writes elsewhere ignored.
- Simultaneous hardware set and W1C of the same bit: set wins.
- Reset: all cnt, high_cnt, period, high_time = 0; valid = stale = 0; FSMs IDLE; synchronizers 0; readdata = 0.

## Timing
- Input to s: 2 cycles; edge detect on s adds 1 more; measurement lag from pin edge to latched registers is 3 cycles, constant, so period and high_time are exact in clk cycles.
- Read: chipselect & read sampled at edge N; readdata valid after edge N+1. readdata holds its last value when not reading.
- Capture latched at edge of rise cycle is visible to a read issued the following cycle.
- Measurable range: period 2..2^CNT_WIDTH-2 cycles; period reaching 2^CNT_WIDTH-1 is stale.
- Reset deasserted mid-PWM: first rise only arms; first valid capture at the second rise.

## Structure
- Shared defines file (the motor-control defines include): `PERIOD_LENGTH`, register address constants (status address 8), status bit-field offsets.
- One sub-module, mda_pwm_capture_channel: synchronizer, edge detect, counter, FSM, period/high_time/valid/stale outputs, W1C inputs. Wrapper instantiates CHANNELS copies in a generate loop and implements the Avalon read mux and status write decode.

## Test plan
- Reset: hold reset low 5 cycles with GPIO_in toggling -> all reads return 0, status 0.
- Steady PWM ch0, high 300 / period 1000 cycles: after second rise, addr 0 reads 0x012C03E8, status bit0 = 1.
- Duty change on ch3 from 250/1000 to 750/1000 at a period boundary: next capture reads 0x02EE03E8 exactly; no mixed pair ever read.
- ch5 held high 70000 cycles after one valid capture: status valid[5] = 0, stale[5] = 1, level[5] = 1; reapplying PWM restores valid after second rise.
- W1C: write 0x00000001 to addr 8 with no edge -> valid[0] cleared; write in the same cycle as a ch0 capture -> valid[0] remains 1.
- Unused address 20 and addr 7 with CHANNELS = 4 -> readdata 0, one-cycle read latency checked on every read.
